// File: rtl/pcie_tlp_arb_rr_if.sv
// TLP merge bus: PORTS input streams plus one output stream, ready/valid.
// slave = arbiter side, master = source/sink side.
interface pcie_tlp_arb_rr_if #(
  parameter int PORTS          = 4,
  parameter int TLP_DATA_WIDTH = 256,
  parameter int TLP_STRB_WIDTH = TLP_DATA_WIDTH/32,
  parameter int TLP_HDR_WIDTH  = 128,
  parameter int SEQ_NUM_WIDTH  = 6
);
  logic [PORTS*TLP_DATA_WIDTH-1:0] in_tlp_data;
  logic [PORTS*TLP_STRB_WIDTH-1:0] in_tlp_strb;
  logic [PORTS*TLP_HDR_WIDTH-1:0]  in_tlp_hdr;
  logic [PORTS*SEQ_NUM_WIDTH-1:0]  in_tlp_seq;
  logic [PORTS*3-1:0]              in_tlp_bar_id;
  logic [PORTS*8-1:0]              in_tlp_func_num;
  logic [PORTS*4-1:0]              in_tlp_error;
  logic [PORTS-1:0]                in_tlp_valid;
  logic [PORTS-1:0]                in_tlp_sop;
  logic [PORTS-1:0]                in_tlp_eop;
  logic [PORTS-1:0]                in_tlp_ready;

  logic [TLP_DATA_WIDTH-1:0]       out_tlp_data;
  logic [TLP_STRB_WIDTH-1:0]       out_tlp_strb;
  logic [TLP_HDR_WIDTH-1:0]        out_tlp_hdr;
  logic [SEQ_NUM_WIDTH-1:0]        out_tlp_seq;
  logic [2:0]                      out_tlp_bar_id;
  logic [7:0]                      out_tlp_func_num;
  logic [3:0]                      out_tlp_error;
  logic                            out_tlp_valid;
  logic                            out_tlp_sop;
  logic                            out_tlp_eop;
  logic                            out_tlp_ready;

  modport slave (
    input  in_tlp_data, in_tlp_strb, in_tlp_hdr, in_tlp_seq,
    input  in_tlp_bar_id, in_tlp_func_num, in_tlp_error,
    input  in_tlp_valid, in_tlp_sop, in_tlp_eop,
    output in_tlp_ready,
    output out_tlp_data, out_tlp_strb, out_tlp_hdr, out_tlp_seq,
    output out_tlp_bar_id, out_tlp_func_num, out_tlp_error,
    output out_tlp_valid, out_tlp_sop, out_tlp_eop,
    input  out_tlp_ready
  );

  modport master (
    output in_tlp_data, in_tlp_strb, in_tlp_hdr, in_tlp_seq,
    output in_tlp_bar_id, in_tlp_func_num, in_tlp_error,
    output in_tlp_valid, in_tlp_sop, in_tlp_eop,
    input  in_tlp_ready,
    input  out_tlp_data, out_tlp_strb, out_tlp_hdr, out_tlp_seq,
    input  out_tlp_bar_id, out_tlp_func_num, out_tlp_error,
    input  out_tlp_valid, out_tlp_sop, out_tlp_eop,
    output out_tlp_ready
  );
endinterface

// File: rtl/pcie_tlp_arb_rr.sv
// Round-robin whole-TLP arbiter, PORTS streams into one registered output.
// Optional per-port eop counters: define PCIE_TLP_ARB_STATS_EN.
module pcie_tlp_arb_rr #(
  parameter int PORTS          = 4,
  parameter int TLP_DATA_WIDTH = 256,
  parameter int TLP_STRB_WIDTH = TLP_DATA_WIDTH/32,
  parameter int TLP_HDR_WIDTH  = 128,
  parameter int SEQ_NUM_WIDTH  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  pcie_tlp_arb_rr_if.slave           bus,
  input  logic                       enable,
  output logic                       grant_active,
  output logic [$clog2(PORTS)-1:0]   grant_index
`ifdef PCIE_TLP_ARB_STATS_EN
  ,
  output logic [PORTS*16-1:0]        stat_tlp_count
`endif
);
  localparam int IW = $clog2(PORTS);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0]    r_state;
  logic [IW-1:0] r_cur;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_gidx;

  logic [PORTS-1:0] w_cand;
  logic [PORTS-1:0] w_rdy;
  logic [IW-1:0]    w_idx;
  logic [IW-1:0]    w_sel;
  logic [IW-1:0]    w_gnt;
  logic             w_gv;
  logic             w_can;
  logic             w_acc;
  logic             w_eop;

  logic [TLP_DATA_WIDTH-1:0] r_data;
  logic [TLP_STRB_WIDTH-1:0] r_strb;
  logic [TLP_HDR_WIDTH-1:0]  r_hdr;
  logic [SEQ_NUM_WIDTH-1:0]  r_seq;
  logic [2:0]                r_bar;
  logic [7:0]                r_func;
  logic [3:0]                r_err;
  logic                      r_valid;
  logic                      r_sop;
  logic                      r_eop;

  // scan downwards so the nearest candidate after r_last wins
  always_comb begin
    w_cand = bus.in_tlp_valid & bus.in_tlp_sop;
    w_sel  = r_last;
    w_idx  = r_last;
    for (int i = PORTS; i >= 1; i--) begin
      w_idx = IW'((int'(r_last) + i) % PORTS);
      if (w_cand[w_idx]) w_sel = w_idx;
    end
  end

  assign w_can = !r_valid || bus.out_tlp_ready;
  assign w_gv  = (r_state == S_ACTIVE) || (enable && |w_cand);
  assign w_gnt = (r_state == S_ACTIVE) ? r_cur : w_sel;
  assign w_acc = !rst && w_gv && w_can && bus.in_tlp_valid[w_gnt];
  assign w_eop = bus.in_tlp_eop[w_gnt];

  always_comb begin
    w_rdy = '0;
    for (int i = 0; i < PORTS; i++)
      w_rdy[i] = !rst && w_gv && w_can && (w_gnt == IW'(i));
  end

  assign bus.in_tlp_ready = w_rdy;
  assign grant_active     = !rst && w_gv;
  assign grant_index      = r_gidx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_last  <= IW'(PORTS-1);
      r_gidx  <= '0;
    end else if (w_acc) begin
      unique case (r_state)
        S_IDLE: begin
          r_cur   <= w_sel;
          r_last  <= w_sel;
          r_gidx  <= w_sel;
          r_state <= w_eop ? S_IDLE : S_ACTIVE;
        end
        S_ACTIVE: if (w_eop) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_data  <= '0;
      r_strb  <= '0;
      r_hdr   <= '0;
      r_seq   <= '0;
      r_bar   <= '0;
      r_func  <= '0;
      r_err   <= '0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_sop   <= bus.in_tlp_sop[w_gnt];
      r_eop   <= w_eop;
      r_data  <= bus.in_tlp_data[w_gnt*TLP_DATA_WIDTH +: TLP_DATA_WIDTH];
      r_strb  <= bus.in_tlp_strb[w_gnt*TLP_STRB_WIDTH +: TLP_STRB_WIDTH];
      r_hdr   <= bus.in_tlp_hdr[w_gnt*TLP_HDR_WIDTH +: TLP_HDR_WIDTH];
      r_seq   <= bus.in_tlp_seq[w_gnt*SEQ_NUM_WIDTH +: SEQ_NUM_WIDTH];
      r_bar   <= bus.in_tlp_bar_id[w_gnt*3 +: 3];
      r_func  <= bus.in_tlp_func_num[w_gnt*8 +: 8];
      r_err   <= bus.in_tlp_error[w_gnt*4 +: 4];
    end else if (bus.out_tlp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_tlp_valid    = r_valid;
  assign bus.out_tlp_sop      = r_sop;
  assign bus.out_tlp_eop      = r_eop;
  assign bus.out_tlp_data     = r_data;
  assign bus.out_tlp_strb     = r_strb;
  assign bus.out_tlp_hdr      = r_hdr;
  assign bus.out_tlp_seq      = r_seq;
  assign bus.out_tlp_bar_id   = r_bar;
  assign bus.out_tlp_func_num = r_func;
  assign bus.out_tlp_error    = r_err;

`ifdef PCIE_TLP_ARB_STATS_EN
  logic [15:0] r_cnt [PORTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PORTS; i++) r_cnt[i] <= '0;
    end else if (w_acc && w_eop) begin
      r_cnt[w_gnt] <= r_cnt[w_gnt] + 16'd1;
    end
  end

  always_comb begin
    stat_tlp_count = '0;
    for (int i = 0; i < PORTS; i++)
      stat_tlp_count[i*16 +: 16] = r_cnt[i];
  end
`endif
endmodule

// File: tb/tb_pcie_tlp_arb_rr.sv
// Directed bench for pcie_tlp_arb_rr: ordering, packet integrity, stalls,
// enable gating and reset recovery against hand-computed beat sequences.
module tb_pcie_tlp_arb_rr;
  localparam int P  = 4;
  localparam int DW = 256;

  typedef struct {
    logic [15:0] tag;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct {
    logic [15:0] tag;
    logic        sop;
    logic        eop;
    logic [1:0]  gi;
    logic        side;
    int          cyc;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       grant_active;
  logic [1:0] grant_index;
`ifdef PCIE_TLP_ARB_STATS_EN
  logic [P*16-1:0] stat_tlp_count;
`endif

  always #5 clk = ~clk;

  pcie_tlp_arb_rr_if #(.PORTS(P)) bus ();

  pcie_tlp_arb_rr #(.PORTS(P)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .enable       (enable),
    .grant_active (grant_active),
    .grant_index  (grant_index)
`ifdef PCIE_TLP_ARB_STATS_EN
    ,
    .stat_tlp_count (stat_tlp_count)
`endif
  );

  beat_t q [P][$];
  obs_t  log_q [$];
  int    st [P];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  logic  oready;
  int    stall_seen, stall_bad;
  logic  was_stall;
  logic [15:0] snap_tag;
  logic  snap_sop, snap_eop;

  task automatic push_tlp(int p, int t, int n);
    beat_t x;
    for (int b = 0; b < n; b++) begin
      x.tag = 16'(p*256 + t*16 + b);
      x.sop = (b == 0);
      x.eop = (b == n-1);
      q[p].push_back(x);
    end
  endtask

  function automatic bit pending();
    for (int p = 0; p < P; p++) if (q[p].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cycle();
    logic [P-1:0] acc;
    logic oacc;
    obs_t o;
    logic [15:0] tg;
    for (int p = 0; p < P; p++) begin
      if (q[p].size() > 0 && cyc >= st[p]) begin
        tg = q[p][0].tag;
        bus.in_tlp_valid[p] = 1'b1;
        bus.in_tlp_sop[p]   = q[p][0].sop;
        bus.in_tlp_eop[p]   = q[p][0].eop;
        bus.in_tlp_data[p*DW +: DW]     = {240'b0, tg};
        bus.in_tlp_hdr[p*128 +: 128]    = {112'b0, tg};
        bus.in_tlp_strb[p*8 +: 8]       = tg[7:0];
        bus.in_tlp_seq[p*6 +: 6]        = tg[5:0];
        bus.in_tlp_bar_id[p*3 +: 3]     = 3'(p);
        bus.in_tlp_func_num[p*8 +: 8]   = tg[7:0];
        bus.in_tlp_error[p*4 +: 4]      = tg[3:0];
      end else begin
        bus.in_tlp_valid[p] = 1'b0;
        bus.in_tlp_sop[p]   = 1'b0;
        bus.in_tlp_eop[p]   = 1'b0;
      end
    end
    bus.out_tlp_ready = oready;
    @(negedge clk);
    acc  = bus.in_tlp_valid & bus.in_tlp_ready;
    oacc = bus.out_tlp_valid && bus.out_tlp_ready;
    if (was_stall && (bus.out_tlp_valid !== 1'b1 ||
        bus.out_tlp_data[15:0] !== snap_tag ||
        bus.out_tlp_sop !== snap_sop || bus.out_tlp_eop !== snap_eop))
      stall_bad++;
    was_stall = bus.out_tlp_valid && !bus.out_tlp_ready;
    if (was_stall) stall_seen++;
    snap_tag = bus.out_tlp_data[15:0];
    snap_sop = bus.out_tlp_sop;
    snap_eop = bus.out_tlp_eop;
    if (oacc) begin
      o.tag  = bus.out_tlp_data[15:0];
      o.sop  = bus.out_tlp_sop;
      o.eop  = bus.out_tlp_eop;
      o.gi   = grant_index;
      o.cyc  = cyc;
      o.side = (bus.out_tlp_hdr[15:0] == o.tag) &&
               (bus.out_tlp_func_num == o.tag[7:0]) &&
               (bus.out_tlp_seq == o.tag[5:0]) &&
               (bus.out_tlp_error == o.tag[3:0]) &&
               (bus.out_tlp_strb == o.tag[7:0]) &&
               (bus.out_tlp_bar_id == o.tag[10:8]);
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < P; p++) if (acc[p]) void'(q[p].pop_front());
    if (oacc) log_q.push_back(o);
    cyc++;
  endtask

  task automatic run(string name, int maxc);
    int n = 0;
    while ((pending() || bus.out_tlp_valid) && n < maxc) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL %s timeout: %0d cycles, want < %0d", name, n, maxc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b1;
    oready = 1'b1;
    for (int p = 0; p < P; p++) begin
      q[p].delete();
      st[p] = 0;
    end
    bus.in_tlp_valid = '0;
    bus.in_tlp_sop = '0;
    bus.in_tlp_eop = '0;
    bus.in_tlp_data = '0;
    bus.in_tlp_strb = '0;
    bus.in_tlp_hdr = '0;
    bus.in_tlp_seq = '0;
    bus.in_tlp_bar_id = '0;
    bus.in_tlp_func_num = '0;
    bus.in_tlp_error = '0;
    bus.out_tlp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
    cyc = 0;
    was_stall = 1'b0;
    stall_seen = 0;
    stall_bad = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    bus.in_tlp_valid = 4'b0001;
    bus.in_tlp_sop = 4'b0001;
    @(negedge clk);
    checks++;
    if (bus.in_tlp_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ready got %b want 0000", bus.in_tlp_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.out_tlp_valid, bus.out_tlp_sop, bus.out_tlp_eop} !== 3'b000) begin
      errors++;
      $display("FAIL rst_qual got %b want 000",
               {bus.out_tlp_valid, bus.out_tlp_sop, bus.out_tlp_eop});
    end
    checks++;
    if (grant_index !== 2'd0 || grant_active !== 1'b0) begin
      errors++;
      $display("FAIL rst_grant got idx=%0d act=%b want 0/0",
               grant_index, grant_active);
    end
    checks++;
    if (bus.out_tlp_data !== '0) begin
      errors++;
      $display("FAIL rst_data got %h want 0", bus.out_tlp_data[15:0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_tlp_ready !== 4'b0001 || grant_active !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_ready got %b/%b want 0001/1",
               bus.in_tlp_ready, grant_active);
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp [4];
    exp = '{16'h000, 16'h100, 16'h200, 16'h300};
    do_reset();
    for (int p = 0; p < P; p++) push_tlp(p, 0, 1);
    run("simul", 20);
    checks++;
    if (log_q.size() != 4) begin
      errors++;
      $display("FAIL simul_count got %0d want 4", log_q.size());
    end
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k].tag !== exp[k] || log_q[k].gi !== 2'(k) ||
          log_q[k].cyc != k+1 || !log_q[k].sop || !log_q[k].eop ||
          !log_q[k].side) begin
        errors++;
        $display("FAIL simul_beat%0d got tag=%h gi=%0d cyc=%0d side=%b want tag=%h gi=%0d cyc=%0d side=1",
                 k, log_q[k].tag, log_q[k].gi, log_q[k].cyc, log_q[k].side,
                 exp[k], k, k+1);
      end
    end
  endtask

  task automatic test_no_interleave();
    logic [15:0] exp [6];
    logic [1:0]  gexp [6];
    exp  = '{16'h100, 16'h101, 16'h102, 16'h103, 16'h200, 16'h201};
    gexp = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    do_reset();
    push_tlp(1, 0, 4);
    push_tlp(2, 0, 2);
    st[2] = 2;
    run("interleave", 30);
    checks++;
    if (log_q.size() != 6) begin
      errors++;
      $display("FAIL interleave_count got %0d want 6", log_q.size());
    end
    for (int k = 0; k < 6 && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k].tag !== exp[k] || log_q[k].gi !== gexp[k] ||
          log_q[k].cyc != k+1) begin
        errors++;
        $display("FAIL interleave_beat%0d got tag=%h gi=%0d cyc=%0d want tag=%h gi=%0d cyc=%0d",
                 k, log_q[k].tag, log_q[k].gi, log_q[k].cyc,
                 exp[k], gexp[k], k+1);
      end
    end
  endtask

  task automatic test_alternation();
    logic [15:0] exp [8];
    exp = '{16'h000, 16'h200, 16'h010, 16'h210,
            16'h020, 16'h220, 16'h030, 16'h230};
    do_reset();
    for (int t = 0; t < 4; t++) begin
      push_tlp(0, t, 1);
      push_tlp(2, t, 1);
    end
    run("alternate", 30);
    checks++;
    if (log_q.size() != 8) begin
      errors++;
      $display("FAIL alternate_count got %0d want 8", log_q.size());
    end
    for (int k = 0; k < 8 && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k].tag !== exp[k] || log_q[k].cyc != k+1) begin
        errors++;
        $display("FAIL alternate_beat%0d got tag=%h cyc=%0d want tag=%h cyc=%0d",
                 k, log_q[k].tag, log_q[k].cyc, exp[k], k+1);
      end
    end
`ifdef PCIE_TLP_ARB_STATS_EN
    checks++;
    if (stat_tlp_count !== {16'd0, 16'd4, 16'd0, 16'd4}) begin
      errors++;
      $display("FAIL alternate_stats got %h want 0000000400000004",
               stat_tlp_count);
    end
`endif
  endtask

  task automatic test_stall();
    logic [15:0] exp [4];
    int n = 0;
    exp = '{16'h100, 16'h101, 16'h102, 16'h103};
    do_reset();
    push_tlp(1, 0, 4);
    while ((pending() || bus.out_tlp_valid) && n < 40) begin
      oready = (n % 2 == 0);
      cycle();
      n++;
    end
    oready = 1'b1;
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL stall timeout: %0d cycles, want < 40", n);
    end
    checks++;
    if (stall_seen == 0 || stall_bad != 0) begin
      errors++;
      $display("FAIL stall_stable got seen=%0d bad=%0d want seen>0 bad=0",
               stall_seen, stall_bad);
    end
    checks++;
    if (log_q.size() != 4) begin
      errors++;
      $display("FAIL stall_count got %0d want 4", log_q.size());
    end
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k].tag !== exp[k] || log_q[k].sop !== (k == 0) ||
          log_q[k].eop !== (k == 3)) begin
        errors++;
        $display("FAIL stall_beat%0d got tag=%h sop=%b eop=%b want tag=%h",
                 k, log_q[k].tag, log_q[k].sop, log_q[k].eop, exp[k]);
      end
    end
  endtask

  task automatic test_enable();
    logic [15:0] exp [5];
    exp = '{16'h300, 16'h301, 16'h302, 16'h000, 16'h100};
    do_reset();
    push_tlp(3, 0, 3);
    cycle();
    checks++;
    if (grant_active !== 1'b1 || grant_index !== 2'd3) begin
      errors++;
      $display("FAIL en_active got act=%b idx=%0d want 1/3",
               grant_active, grant_index);
    end
    enable = 1'b0;
    push_tlp(0, 0, 1);
    push_tlp(1, 0, 1);
    repeat (8) cycle();
    checks++;
    if (log_q.size() != 3) begin
      errors++;
      $display("FAIL en_off_count got %0d want 3", log_q.size());
    end
    checks++;
    if (bus.out_tlp_valid !== 1'b0 || grant_active !== 1'b0 ||
        bus.in_tlp_ready !== 4'b0000) begin
      errors++;
      $display("FAIL en_off_idle got v=%b act=%b rdy=%b want 0/0/0000",
               bus.out_tlp_valid, grant_active, bus.in_tlp_ready);
    end
    enable = 1'b1;
    run("enable", 20);
    checks++;
    if (log_q.size() != 5) begin
      errors++;
      $display("FAIL en_count got %0d want 5", log_q.size());
    end
    for (int k = 0; k < 5 && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k].tag !== exp[k]) begin
        errors++;
        $display("FAIL en_beat%0d got tag=%h want %h",
                 k, log_q[k].tag, exp[k]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [15:0] exp [4];
    exp = '{16'h010, 16'h110, 16'h210, 16'h310};
    do_reset();
    push_tlp(1, 0, 1);
    push_tlp(0, 0, 5);
    st[0] = 1;
    repeat (3) cycle();
`ifdef PCIE_TLP_ARB_STATS_EN
    checks++;
    if (stat_tlp_count[31:16] !== 16'd1) begin
      errors++;
      $display("FAIL pre_rst_stats got %0d want 1", stat_tlp_count[31:16]);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_tlp_ready !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_ready got %b want 0000", bus.in_tlp_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_tlp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_valid got %b want 0", bus.out_tlp_valid);
    end
    rst = 1'b0;
`ifdef PCIE_TLP_ARB_STATS_EN
    checks++;
    if (stat_tlp_count !== '0) begin
      errors++;
      $display("FAIL midrst_stats got %h want 0", stat_tlp_count);
    end
`endif
    for (int p = 0; p < P; p++) begin
      q[p].delete();
      st[p] = 0;
    end
    log_q.delete();
    cyc = 0;
    for (int p = 0; p < P; p++) push_tlp(p, 1, 1);
    run("midrst", 20);
    checks++;
    if (log_q.size() != 4) begin
      errors++;
      $display("FAIL midrst_count got %0d want 4", log_q.size());
    end
    for (int k = 0; k < 4 && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k].tag !== exp[k]) begin
        errors++;
        $display("FAIL midrst_beat%0d got tag=%h want %h",
                 k, log_q[k].tag, exp[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_simultaneous();
    test_no_interleave();
    test_alternation();
    test_stall();
    test_enable();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
